// File: rtl/traffic_light_pkg.sv
// Lamp encodings, phase/fault enums and FSM states
// shared by the traffic light monitor and lamp drivers.
package traffic_light_pkg;

  localparam logic [2:0] LAMP_RED = 3'b100;
  localparam logic [2:0] LAMP_YEL = 3'b010;
  localparam logic [2:0] LAMP_GRN = 3'b001;

  typedef enum logic [2:0] {
    PH_P0      = 3'd0,
    PH_P1      = 3'd1,
    PH_P2      = 3'd2,
    PH_P3      = 3'd3,
    PH_ALLRED  = 3'd4,
    PH_INVALID = 3'd5
  } phase_e;

  typedef enum logic [2:0] {
    FC_NONE     = 3'd0,
    FC_CONFLICT = 3'd1,
    FC_ENCODING = 3'd2,
    FC_SEQUENCE = 3'd3,
    FC_SHORT    = 3'd4,
    FC_LONG     = 3'd5
  } fault_e;

  typedef enum logic [1:0] {
    ST_SYNC   = 2'd0,
    ST_LOCKED = 2'd1,
    ST_FAULT  = 2'd2
  } state_e;

  function automatic logic [1:0] next_phase(
    input logic [1:0] p
  );
    return p + 2'd1;
  endfunction

endpackage

// File: rtl/tl_phase_decoder.sv
// Maps an (ns, ew) lamp pair onto the phase enum.
// Anything outside the five legal pairs is PH_INVALID.
module tl_phase_decoder
  import traffic_light_pkg::*;
(
  input  logic [2:0] ns,
  input  logic [2:0] ew,
  output phase_e     ph
);

  always_comb begin
    ph = PH_INVALID;
    unique case ({ns, ew})
      {LAMP_GRN, LAMP_RED}: ph = PH_P0;
      {LAMP_YEL, LAMP_RED}: ph = PH_P1;
      {LAMP_RED, LAMP_GRN}: ph = PH_P2;
      {LAMP_RED, LAMP_YEL}: ph = PH_P3;
      {LAMP_RED, LAMP_RED}: ph = PH_ALLRED;
      default:              ph = PH_INVALID;
    endcase
  end

endmodule

// File: rtl/traffic_light_monitor.sv
// Traffic light sequence monitor with sticky fault latch.
// Define TRAFFIC_LIGHT_MONITOR_DWELL_CHECK_EN for dwell checks.
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int MIN_DWELL = 10,
  parameter int MAX_DWELL = 10
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] ns_light,
  input  logic [2:0] ew_light,
  input  logic       fault_clr,
  output logic [1:0] phase,
  output logic       phase_valid,
  output logic       fault,
  output logic [2:0] fault_code,
  output logic [7:0] cycle_count
);

  if (MIN_DWELL < 1 || MAX_DWELL < MIN_DWELL) begin : g_bad_cfg
    $error("traffic_light_monitor: bad dwell bounds");
  end

  state_e     state_q, state_d;
  logic [1:0] phase_q, phase_d;
  logic       have_q, have_d;
  logic       fault_q, fault_d;
  fault_e     code_q, code_d;
  logic [7:0] count_q, count_d;

  logic [2:0] ns_q, ew_q;
  phase_e     dph;
  logic [2:0] dph_b;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ns_q <= LAMP_RED;
      ew_q <= LAMP_RED;
    end else begin
      ns_q <= ns_light;
      ew_q <= ew_light;
    end
  end

  tl_phase_decoder u_dec (
    .ns (ns_q),
    .ew (ew_q),
    .ph (dph)
  );

  assign dph_b = dph;

  logic is_p, chg, fwd, locked;
  logic conflict_v, enc_v, seq_v;
  logic short_v, long_v;

  assign is_p   = !dph_b[2];
  assign chg    = is_p && (dph_b[1:0] != phase_q);
  assign fwd    = dph_b[1:0] == next_phase(phase_q);
  assign locked = state_q == ST_LOCKED;

  assign conflict_v = !ns_q[2] && !ew_q[2];
  assign enc_v      = dph == PH_INVALID;
  assign seq_v      = locked &&
                      (dph == PH_ALLRED || (chg && !fwd));

  fault_e code;

  always_comb begin
    code = FC_NONE;
    if (conflict_v)   code = FC_CONFLICT;
    else if (enc_v)   code = FC_ENCODING;
    else if (seq_v)   code = FC_SEQUENCE;
    else if (short_v) code = FC_SHORT;
    else if (long_v)  code = FC_LONG;
  end

`ifdef TRAFFIC_LIGHT_MONITOR_DWELL_CHECK_EN
  localparam int DW = $clog2(MAX_DWELL + 2);
  localparam logic [DW-1:0] MIN_D = DW'(MIN_DWELL);
  localparam logic [DW-1:0] MAX_D = DW'(MAX_DWELL);

  logic [DW-1:0] dwell_q, dwell_d;

  assign short_v = locked && chg && fwd &&
                   (dwell_q < MIN_D);
  assign long_v  = locked && is_p && !chg &&
                   (dwell_q >= MAX_D);

  // dwell counts registered samples of the current phase
  always_comb begin
    dwell_d = dwell_q;
    unique case (state_q)
      ST_SYNC: begin
        dwell_d = '0;
        if (code == FC_NONE && have_q && chg)
          dwell_d = DW'(1);
      end
      ST_LOCKED: begin
        if (code == FC_NONE)
          dwell_d = chg ? DW'(1) : dwell_q + DW'(1);
      end
      ST_FAULT: begin
        if (fault_clr) dwell_d = '0;
      end
      default: dwell_d = '0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) dwell_q <= '0;
    else       dwell_q <= dwell_d;
  end
`else
  assign short_v = 1'b0;
  assign long_v  = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    have_d  = have_q;
    fault_d = fault_q;
    code_d  = code_q;
    count_d = count_q;
    unique case (state_q)
      ST_SYNC, ST_LOCKED: begin
        if (code != FC_NONE) begin
          state_d = ST_FAULT;
          fault_d = 1'b1;
          code_d  = code;
        end else if (is_p) begin
          phase_d = dph_b[1:0];
          have_d  = 1'b1;
          if (!locked && have_q && chg)
            state_d = ST_LOCKED;
          if (locked && chg && phase_q == 2'd3)
            count_d = count_q + 8'd1;
        end
      end
      ST_FAULT: begin
        if (fault_clr) begin
          state_d = ST_SYNC;
          fault_d = 1'b0;
          code_d  = FC_NONE;
          have_d  = 1'b0;
        end
      end
      default: state_d = ST_SYNC;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_SYNC;
      phase_q <= 2'd0;
      have_q  <= 1'b0;
      fault_q <= 1'b0;
      code_q  <= FC_NONE;
      count_q <= 8'd0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      have_q  <= have_d;
      fault_q <= fault_d;
      code_q  <= code_d;
      count_q <= count_d;
    end
  end

  assign phase       = phase_q;
  assign phase_valid = state_q == ST_LOCKED;
  assign fault       = fault_q;
  assign fault_code  = code_q;
  assign cycle_count = count_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Directed bench for traffic_light_monitor; a sample set
// before edge N shows up in the outputs after edge N+1.
module tb_traffic_light_monitor;
  import traffic_light_pkg::*;

`ifdef TRAFFIC_LIGHT_MONITOR_DWELL_CHECK_EN
  localparam bit DWELL = 1'b1;
`else
  localparam bit DWELL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] ns_light = LAMP_RED;
  logic [2:0] ew_light = LAMP_RED;
  logic       fault_clr = 1'b0;
  logic [1:0] phase;
  logic       phase_valid;
  logic       fault;
  logic [2:0] fault_code;
  logic [7:0] cycle_count;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  traffic_light_monitor dut (
    .clk         (clk),
    .reset       (reset),
    .ns_light    (ns_light),
    .ew_light    (ew_light),
    .fault_clr   (fault_clr),
    .phase       (phase),
    .phase_valid (phase_valid),
    .fault       (fault),
    .fault_code  (fault_code),
    .cycle_count (cycle_count)
  );

  function automatic logic [2:0] ns_of(input int p);
    case (p)
      0:       return LAMP_GRN;
      1:       return LAMP_YEL;
      default: return LAMP_RED;
    endcase
  endfunction

  function automatic logic [2:0] ew_of(input int p);
    case (p)
      2:       return LAMP_GRN;
      3:       return LAMP_YEL;
      default: return LAMP_RED;
    endcase
  endfunction

  task automatic cyc(input logic [2:0] n, input logic [2:0] e,
                     input logic c);
    @(negedge clk);
    ns_light  = n;
    ew_light  = e;
    fault_clr = c;
  endtask

  task automatic run(input int p, input int k);
    for (int i = 0; i < k; i++) cyc(ns_of(p), ew_of(p), 1'b0);
  endtask

  task automatic do_reset;
    @(negedge clk);
    reset = 1'b1;
    ns_light = LAMP_RED;
    ew_light = LAMP_RED;
    fault_clr = 1'b0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  // P3 then one P0 sample: locks with P0 dwell at 1
  task automatic lock_p0;
    do_reset();
    run(3, 10);
    run(0, 1);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (phase !== 2'd0) begin n_bad++; $display("FAIL rst_phase: got %0d want 0", phase); end
    n_cmp++; if (phase_valid !== 1'b0) begin n_bad++; $display("FAIL rst_pvalid: got %0d want 0", phase_valid); end
    n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL rst_fault: got %0d want 0", fault); end
    n_cmp++; if (fault_code !== 3'd0) begin n_bad++; $display("FAIL rst_code: got %0d want 0", fault_code); end
    n_cmp++; if (cycle_count !== 8'd0) begin n_bad++; $display("FAIL rst_count: got %0d want 0", cycle_count); end
    reset = 1'b0;
    repeat (3) cyc(LAMP_RED, LAMP_RED, 1'b0);
    n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL allred_fault: got %0d want 0", fault); end
  endtask

  task automatic test_rotation;
    do_reset();
    run(0, 10);
    n_cmp++; if (phase_valid !== 1'b0) begin n_bad++; $display("FAIL rot_sync_pv: got %0d want 0", phase_valid); end
    run(1, 10);
    n_cmp++; if (phase_valid !== 1'b1) begin n_bad++; $display("FAIL rot_lock_pv: got %0d want 1", phase_valid); end
    n_cmp++; if (phase !== 2'd1) begin n_bad++; $display("FAIL rot_lock_phase: got %0d want 1", phase); end
    run(2, 10);
    run(3, 10);
    for (int r = 0; r < 2; r++) begin
      run(0, 10); run(1, 10); run(2, 10); run(3, 10);
    end
    n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL rot_fault: got %0d want 0", fault); end
    n_cmp++; if (phase_valid !== 1'b1) begin n_bad++; $display("FAIL rot_pv: got %0d want 1", phase_valid); end
    n_cmp++; if (cycle_count !== 8'd2) begin n_bad++; $display("FAIL rot_count: got %0d want 2", cycle_count); end
    n_cmp++; if (phase !== 2'd3) begin n_bad++; $display("FAIL rot_phase: got %0d want 3", phase); end
  endtask

  task automatic test_conflict;
    lock_p0();
    run(0, 4);
    cyc(LAMP_GRN, LAMP_GRN, 1'b0);
    run(2, 2);
    n_cmp++; if (fault !== 1'b1) begin n_bad++; $display("FAIL cfl_fault: got %0d want 1", fault); end
    n_cmp++; if (fault_code !== 3'd1) begin n_bad++; $display("FAIL cfl_code: got %0d want 1", fault_code); end
    n_cmp++; if (phase_valid !== 1'b0) begin n_bad++; $display("FAIL cfl_pv: got %0d want 0", phase_valid); end
    run(2, 5);
    n_cmp++; if (fault_code !== 3'd1) begin n_bad++; $display("FAIL cfl_hold_code: got %0d want 1", fault_code); end
    n_cmp++; if (phase !== 2'd0) begin n_bad++; $display("FAIL cfl_hold_phase: got %0d want 0", phase); end
    cyc(ns_of(2), ew_of(2), 1'b1);
    run(2, 1);
    n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL cfl_clr_fault: got %0d want 0", fault); end
    n_cmp++; if (fault_code !== 3'd0) begin n_bad++; $display("FAIL cfl_clr_code: got %0d want 0", fault_code); end
    run(2, 1);
    n_cmp++; if (phase !== 2'd2) begin n_bad++; $display("FAIL cfl_sync_phase: got %0d want 2", phase); end
  endtask

  task automatic test_persist;
    do_reset();
    repeat (3) cyc(LAMP_GRN, LAMP_YEL, 1'b0);
    n_cmp++; if (fault_code !== 3'd1) begin n_bad++; $display("FAIL per_code: got %0d want 1", fault_code); end
    cyc(LAMP_GRN, LAMP_YEL, 1'b1);
    cyc(LAMP_GRN, LAMP_YEL, 1'b0);
    n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL per_clr: got %0d want 0", fault); end
    cyc(LAMP_GRN, LAMP_YEL, 1'b0);
    n_cmp++; if (fault !== 1'b1) begin n_bad++; $display("FAIL per_again: got %0d want 1", fault); end
  endtask

  task automatic test_encoding;
    do_reset();
    cyc(3'b110, LAMP_RED, 1'b0);
    repeat (2) cyc(LAMP_RED, LAMP_RED, 1'b0);
    n_cmp++; if (fault_code !== 3'd2) begin n_bad++; $display("FAIL enc_code: got %0d want 2", fault_code); end
  endtask

  task automatic test_sequence;
    lock_p0();
    run(0, 9);
    run(1, 10);
    run(3, 3);
    n_cmp++; if (fault_code !== 3'd3) begin n_bad++; $display("FAIL seq_code: got %0d want 3", fault_code); end
    n_cmp++; if (phase !== 2'd1) begin n_bad++; $display("FAIL seq_phase: got %0d want 1", phase); end
    cyc(ns_of(3), ew_of(3), 1'b1);
    run(3, 1);
    n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL seq_clr: got %0d want 0", fault); end
    n_cmp++; if (phase_valid !== 1'b0) begin n_bad++; $display("FAIL seq_sync: got %0d want 0", phase_valid); end
  endtask

  task automatic test_allred_locked;
    lock_p0();
    run(0, 5);
    cyc(LAMP_RED, LAMP_RED, 1'b0);
    run(0, 2);
    n_cmp++; if (fault_code !== 3'd3) begin n_bad++; $display("FAIL allred_code: got %0d want 3", fault_code); end
  endtask

  task automatic test_short;
    lock_p0();
    run(0, 5);
    run(1, 3);
    n_cmp++; if (fault !== DWELL) begin n_bad++; $display("FAIL short_fault: got %0d want %0d", fault, DWELL); end
    n_cmp++; if (fault_code !== (DWELL ? 3'd4 : 3'd0)) begin n_bad++; $display("FAIL short_code: got %0d want %0d", fault_code, DWELL ? 4 : 0); end
  endtask

  task automatic test_long;
    lock_p0();
    run(0, 9);
    run(1, 10);
    run(2, 13);
    n_cmp++; if (fault !== DWELL) begin n_bad++; $display("FAIL long_fault: got %0d want %0d", fault, DWELL); end
    n_cmp++; if (fault_code !== (DWELL ? 3'd5 : 3'd0)) begin n_bad++; $display("FAIL long_code: got %0d want %0d", fault_code, DWELL ? 5 : 0); end
    n_cmp++; if (phase !== 2'd2) begin n_bad++; $display("FAIL long_phase: got %0d want 2", phase); end
  endtask

  task automatic test_wrap;
    lock_p0();
    run(0, 9);
    for (int r = 0; r < 256; r++) begin
      run(1, 10); run(2, 10); run(3, 10); run(0, 10);
      if (r == 0 || r == 254) begin
        n_cmp++; if (cycle_count !== 8'(r + 1)) begin n_bad++; $display("FAIL wrap_mid: got %0d want %0d", cycle_count, r + 1); end
      end
    end
    n_cmp++; if (cycle_count !== 8'd0) begin n_bad++; $display("FAIL wrap_zero: got %0d want 0", cycle_count); end
    n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL wrap_fault: got %0d want 0", fault); end
    run(1, 10); run(2, 10); run(3, 10); run(0, 10); run(1, 5);
    n_cmp++; if (cycle_count !== 8'd1) begin n_bad++; $display("FAIL pre_rst_count: got %0d want 1", cycle_count); end
    n_cmp++; if (phase !== 2'd1) begin n_bad++; $display("FAIL pre_rst_phase: got %0d want 1", phase); end
    reset = 1'b1;
    #1;
    n_cmp++; if (cycle_count !== 8'd0) begin n_bad++; $display("FAIL arst_count: got %0d want 0", cycle_count); end
    n_cmp++; if (phase !== 2'd0) begin n_bad++; $display("FAIL arst_phase: got %0d want 0", phase); end
    n_cmp++; if (phase_valid !== 1'b0) begin n_bad++; $display("FAIL arst_pv: got %0d want 0", phase_valid); end
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset_in_fault;
    do_reset();
    cyc(LAMP_GRN, LAMP_GRN, 1'b0);
    run(0, 2);
    n_cmp++; if (fault !== 1'b1) begin n_bad++; $display("FAIL prf_fault: got %0d want 1", fault); end
    reset = 1'b1;
    #1;
    n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL arf_fault: got %0d want 0", fault); end
    n_cmp++; if (fault_code !== 3'd0) begin n_bad++; $display("FAIL arf_code: got %0d want 0", fault_code); end
    @(negedge clk);
    reset = 1'b0;
    run(0, 3);
    n_cmp++; if (fault !== 1'b0) begin n_bad++; $display("FAIL arf_after: got %0d want 0", fault); end
    n_cmp++; if (phase_valid !== 1'b0) begin n_bad++; $display("FAIL arf_pv: got %0d want 0", phase_valid); end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_rotation();
    test_conflict();
    test_persist();
    test_encoding();
    test_sequence();
    test_allred_locked();
    test_short();
    test_long();
    test_wrap();
    test_reset_in_fault();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
